// File: rtl/fifo_pkg.sv
// fifo_pkg: shared geometry helper, status record and parameter legality macros for the FIFO
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_IS_POW2(n) ((n) >= 4 && (((n) & ((n) - 1)) == 0))
`define FIFO_THR_OK(d, af, ae) ((af) >= 1 && (af) <= (d) && (ae) >= 0 && (ae) < (d))
`endif
package fifo_pkg;
  function automatic int clog2w(input int n);
    return $clog2(n);
  endfunction
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port RAM, one write port, one registered read port, no array reset
module fifo_sdp_ram import fifo_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int AW = clog2w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO; define FIFO_SHOWAHEAD_EN for first-word fall-through
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int AFULL_THR = 240,
  parameter int AEMPTY_THR = 16
) (
  input  logic                       clk,
  input  logic                       sclr,
  input  logic [DATA_W-1:0]          data,
  input  logic                       wrreq,
  input  logic                       rdreq,
  output logic [DATA_W-1:0]          q,
  output logic [clog2w(DEPTH):0]     usedw,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = clog2w(DEPTH);
  localparam int CW = AW + 1;
  if (!(`FIFO_IS_POW2(DEPTH) && `FIFO_THR_OK(DEPTH, AFULL_THR, AEMPTY_THR) && DATA_W >= 1)) begin : g_bad
    $error("sync_fifo_param: illegal DATA_W/DEPTH/threshold combination");
  end
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_n;
  fifo_status_t st;
  logic wok, rok, we, re;
  logic [DATA_W-1:0] rdata;
  assign wok = wrreq && !st.full;
  assign rok = rdreq && !st.empty;
  assign cnt_n = cnt + CW'(wok) - CW'(rok);
`ifdef FIFO_SHOWAHEAD_EN
  // Head word lives in byp when it bypassed the RAM, otherwise in the RAM read register
  logic [DATA_W-1:0] byp;
  logic sel, bp;
  assign bp = wok && (cnt == '0 || (rok && cnt == CW'(1)));
  assign we = wok && !bp;
  assign re = rok && cnt > CW'(1);
  assign q = sel ? rdata : byp;
  always_ff @(posedge clk)
    if (sclr) begin
      byp <= '0;
      sel <= 1'b0;
    end else if (bp) begin
      byp <= data;
      sel <= 1'b0;
    end else if (re) sel <= 1'b1;
`else
  assign we = wok;
  assign re = rok;
  assign q = rdata;
`endif
  always_ff @(posedge clk)
    if (sclr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      st <= '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      cnt <= cnt_n;
      st <= '{cnt_n == '0, cnt_n == CW'(DEPTH), cnt_n <= CW'(AEMPTY_THR), cnt_n >= CW'(AFULL_THR),
              st.overflow | (wrreq && st.full), st.underflow | (rdreq && st.empty)};
    end
  fifo_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .rst(sclr), .we(we), .waddr(wp), .wdata(data),
    .re(re), .raddr(rp), .rdata(rdata)
  );
  assign usedw = cnt;
  assign empty = st.empty;
  assign full = st.full;
  assign almost_empty = st.almost_empty;
  assign almost_full = st.almost_full;
  assign overflow = st.overflow;
  assign underflow = st.underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random checks of sync_fifo_param against a queue-based model
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 3;
  logic clk = 1'b0;
  logic sclr = 1'b1, wrreq = 1'b0, rdreq = 1'b0;
  logic [DW-1:0] data = '0, q;
  logic [4:0] usedw;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  int nchk = 0, nfail = 0;
  logic [DW-1:0] mq [$];
  logic [DW-1:0] qe = '0;
  logic ovf_e = 1'b0, unf_e = 1'b0;
  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THR(AF), .AEMPTY_THR(AE)) dut (
    .clk(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .q(q),
    .usedw(usedw), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic s, input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    if (s) begin
      mq.delete();
      qe = '0;
      ovf_e = 1'b0;
      unf_e = 1'b0;
    end else begin
      wa = w && mq.size() < DEPTH;
      ra = r && mq.size() > 0;
      if (w && !wa) ovf_e = 1'b1;
      if (r && !ra) unf_e = 1'b1;
`ifndef FIFO_SHOWAHEAD_EN
      if (ra) qe = mq[0];
`endif
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(d);
`ifdef FIFO_SHOWAHEAD_EN
      if (mq.size() > 0) qe = mq[0];
`endif
    end
  endtask
  task automatic cyc(input logic s, input logic w, input logic r, input logic [DW-1:0] d);
    int n;
    sclr = s;
    wrreq = w;
    rdreq = r;
    data = d;
    @(posedge clk);
    model(s, w, r, d);
    #1;
    n = mq.size();
    chk("usedw", 32'(usedw), 32'(n));
    chk("level_flags", {empty, full, almost_empty, almost_full},
        {n == 0, n == DEPTH, n <= AE, n >= AF});
    chk("sticky_flags", {overflow, underflow}, {ovf_e, unf_e});
    chk("q", 32'(q), 32'(qe));
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 8'h33);
    chk("reset_usedw", 32'(usedw), 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, DW'(i));
    chk("fill_usedw", 32'(usedw), 16);
    chk("fill_full", 32'(full), 1);
    cyc(0, 1, 0, 8'hEE);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_usedw_after_ovf", 32'(usedw), 16);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 0, 1, 0);
    chk("drain_underflow", 32'(underflow), 1);
    chk("drain_q_hold", 32'(q), 15);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, i % 3 != 2, i % 3 == 2, DW'($urandom));
    for (int i = 0; i < 30; i++) cyc(0, i % 3 == 0, i % 3 != 0, DW'($urandom));
    chk("wrap_empty", 32'(empty), 1);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 8'h11);
    chk("rw_at_0", 32'(usedw), 1);
    cyc(0, 1, 1, 8'h22);
    chk("rw_at_1", 32'(usedw), 1);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, DW'($urandom));
    cyc(0, 1, 1, 8'h44);
    chk("rw_at_15", 32'(usedw), 15);
    cyc(0, 1, 0, 8'h55);
    cyc(0, 1, 1, 8'h66);
    chk("rw_at_16", 32'(usedw), 15);
    chk("rw_at_16_ovf", 32'(overflow), 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, DW'(8'h80 + i));
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 8'h90);
    cyc(1, 1, 0, 8'h99);
    chk("midreset_usedw", 32'(usedw), 0);
    chk("midreset_sticky", {30'd0, overflow, underflow}, 0);
    cyc(0, 0, 0, 0);
    chk("midreset_not_stored", 32'(empty), 1);
    cyc(0, 1, 0, 8'hA5);
`ifdef FIFO_SHOWAHEAD_EN
    chk("sa_q", 32'(q), 32'hA5);
`endif
    chk("sa_not_empty", 32'(empty), 0);
    cyc(0, 0, 1, 0);
    chk("sa_empty_after_pop", 32'(empty), 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < (i < 200 ? 60 : 40),
          $urandom_range(0, 99) < (i < 200 ? 40 : 60), DW'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
